// File: rtl/board_state_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | board_state_mem : R x C piece-code board with start-position load,   |
// | two-step moves, direct square writes and a circular undo history.    |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module board_state_mem #(
  parameter int ROW_BITS   = 3,
  parameter int COL_BITS   = 3,
  parameter int PIECE_W    = 4,
  parameter int UNDO_DEPTH = 16
) (
  input  logic                                             CLK,
  input  logic                                             RESET,
  input  logic                                             MOVE_VALID,
  input  logic [ROW_BITS+COL_BITS-1:0]                     MOVE_SRC,
  input  logic [ROW_BITS+COL_BITS-1:0]                     MOVE_DST,
  input  logic                                             UNDO_VALID,
  input  logic                                             WR_VALID,
  input  logic [ROW_BITS+COL_BITS-1:0]                     WR_ADDR,
  input  logic [PIECE_W-1:0]                               WR_PIECE,
  output logic                                             READY,
  output logic                                             DONE,
  output logic                                             CMD_ERR,
  output logic [$clog2(UNDO_DEPTH):0]                      UNDO_COUNT,
  output logic [(2**(ROW_BITS+COL_BITS))*PIECE_W-1:0]      BOARD_OUT
);

  localparam int A  = ROW_BITS + COL_BITS;
  localparam int N  = 2**A;
  localparam int R  = 2**ROW_BITS;
  localparam int PW = $clog2(UNDO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(UNDO_DEPTH);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_MOVE2 = 2'd2,
    ST_UNDO2 = 2'd3
  } state_t;

  state_t               state, state_next;
  logic [PIECE_W-1:0]   board [N];
  logic [A-1:0]         hist_src  [UNDO_DEPTH];
  logic [A-1:0]         hist_dst  [UNDO_DEPTH];
  logic [PIECE_W-1:0]   hist_sp   [UNDO_DEPTH];
  logic [PIECE_W-1:0]   hist_dold [UNDO_DEPTH];

  logic [A-1:0]         init_k, init_k_next;
  logic [PW-1:0]        wr_ptr, ptr_next, top_ptr;
  logic [CW-1:0]        count_next;
  logic                 ready_next, done_next, err_next;
  logic                 bw_en;
  logic [A-1:0]         bw_addr;
  logic [PIECE_W-1:0]   bw_data;
  logic [A-1:0]         pend_addr, pend_addr_next;
  logic [PIECE_W-1:0]   pend_data, pend_data_next;
  logic                 push;
  logic [PIECE_W-1:0]   src_piece, dst_piece;

  assign src_piece = board[MOVE_SRC];
  assign dst_piece = board[MOVE_DST];
  assign top_ptr   = wr_ptr - PW'(1);

  // Starting position: black on rows 0/1, white on rows R-2/R-1.
  function automatic logic [PIECE_W-1:0] init_piece(input logic [A-1:0] sq);
    logic [ROW_BITS-1:0] row;
    logic [2:0]          col8;
    logic [2:0]          back;
    logic [PIECE_W-1:0]  p;
    row  = sq[A-1:COL_BITS];
    col8 = 3'(sq[COL_BITS-1:0]);
    case (col8)
      3'd0, 3'd7: back = 3'd4;
      3'd1, 3'd6: back = 3'd2;
      3'd2, 3'd5: back = 3'd3;
      3'd3:       back = 3'd5;
      default:    back = 3'd6;
    endcase
    p = '0;
    if (row == '0) begin
      p[2:0]         = back;
      p[PIECE_W-1]   = 1'b1;
    end else if (row == ROW_BITS'(1)) begin
      p[2:0]         = 3'd1;
      p[PIECE_W-1]   = 1'b1;
    end else if (row == ROW_BITS'(R-2)) begin
      p[2:0]         = 3'd1;
    end else if (row == ROW_BITS'(R-1)) begin
      p[2:0]         = back;
    end
    return p;
  endfunction

  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_INIT;
    else       state <= state_next;
  end

  always_comb begin
    state_next     = state;
    init_k_next    = init_k;
    ptr_next       = wr_ptr;
    count_next     = UNDO_COUNT;
    ready_next     = 1'b0;
    done_next      = 1'b0;
    err_next       = 1'b0;
    bw_en          = 1'b0;
    bw_addr        = '0;
    bw_data        = '0;
    pend_addr_next = pend_addr;
    pend_data_next = pend_data;
    push           = 1'b0;
    case (state)
      ST_INIT: begin
        bw_en       = 1'b1;
        bw_addr     = init_k;
        bw_data     = init_piece(init_k);
        init_k_next = init_k + A'(1);
        if (init_k == A'(N-1)) begin
          state_next = ST_IDLE;
          ready_next = 1'b1;
        end
      end
      ST_IDLE: begin
        ready_next = 1'b1;
        if (UNDO_VALID) begin
          err_next = MOVE_VALID | WR_VALID;
          if (UNDO_COUNT == '0) begin
            err_next = 1'b1;
          end else begin
            ptr_next       = top_ptr;
            count_next     = UNDO_COUNT - CW'(1);
            bw_en          = 1'b1;
            bw_addr        = hist_dst[top_ptr];
            bw_data        = hist_dold[top_ptr];
            pend_addr_next = hist_src[top_ptr];
            pend_data_next = hist_sp[top_ptr];
            state_next     = ST_UNDO2;
            ready_next     = 1'b0;
          end
        end else if (MOVE_VALID) begin
          err_next = WR_VALID;
          if ((MOVE_SRC == MOVE_DST) || (src_piece[2:0] == 3'd0)) begin
            err_next = 1'b1;
          end else begin
            bw_en          = 1'b1;
            bw_addr        = MOVE_DST;
            bw_data        = src_piece;
            push           = 1'b1;
            ptr_next       = wr_ptr + PW'(1);
            // A full history keeps its count; the oldest slot is overwritten.
            count_next     = (UNDO_COUNT == FULL_COUNT) ? FULL_COUNT : UNDO_COUNT + CW'(1);
            pend_addr_next = MOVE_SRC;
            pend_data_next = '0;
            state_next     = ST_MOVE2;
            ready_next     = 1'b0;
          end
        end else if (WR_VALID) begin
          bw_en      = 1'b1;
          bw_addr    = WR_ADDR;
          bw_data    = WR_PIECE;
          count_next = '0;
          done_next  = 1'b1;
        end
      end
      ST_MOVE2, ST_UNDO2: begin
        bw_en      = 1'b1;
        bw_addr    = pend_addr;
        bw_data    = pend_data;
        state_next = ST_IDLE;
        done_next  = 1'b1;
        ready_next = 1'b1;
      end
      default: state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      init_k     <= '0;
      wr_ptr     <= '0;
      UNDO_COUNT <= '0;
      READY      <= 1'b0;
      DONE       <= 1'b0;
      CMD_ERR    <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
      for (int i = 0; i < N; i++) board[i] <= '0;
    end else begin
      init_k     <= init_k_next;
      wr_ptr     <= ptr_next;
      UNDO_COUNT <= count_next;
      READY      <= ready_next;
      DONE       <= done_next;
      CMD_ERR    <= err_next;
      pend_addr  <= pend_addr_next;
      pend_data  <= pend_data_next;
      if (bw_en) board[bw_addr] <= bw_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      hist_src[wr_ptr]  <= MOVE_SRC;
      hist_dst[wr_ptr]  <= MOVE_DST;
      hist_sp[wr_ptr]   <= src_piece;
      hist_dold[wr_ptr] <= dst_piece;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_flat
    assign BOARD_OUT[g*PIECE_W +: PIECE_W] = board[g];
  end

endmodule
`default_nettype wire

// File: tb/tb_board_state_mem.sv
`default_nettype none
// Scoreboard bench for board_state_mem: a move/undo reference model predicts
// every DONE / CMD_ERR pulse, its cycle, the undo count and the board.
module tb_board_state_mem;

  localparam int RB    = 3;
  localparam int CB    = 3;
  localparam int PWD   = 4;
  localparam int DEPTH = 4;
  localparam int AW    = RB + CB;
  localparam int N     = 1 << AW;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic               clk = 1'b0;
  logic               RESET;
  logic               MOVE_VALID, UNDO_VALID, WR_VALID;
  logic [AW-1:0]      MOVE_SRC, MOVE_DST, WR_ADDR;
  logic [PWD-1:0]     WR_PIECE;
  logic               READY, DONE, CMD_ERR;
  logic [CW-1:0]      UNDO_COUNT;
  logic [N*PWD-1:0]   BOARD_OUT;

  board_state_mem #(.ROW_BITS(RB), .COL_BITS(CB), .PIECE_W(PWD), .UNDO_DEPTH(DEPTH)) dut (
    .CLK(clk), .RESET(RESET), .MOVE_VALID(MOVE_VALID), .MOVE_SRC(MOVE_SRC),
    .MOVE_DST(MOVE_DST), .UNDO_VALID(UNDO_VALID), .WR_VALID(WR_VALID),
    .WR_ADDR(WR_ADDR), .WR_PIECE(WR_PIECE), .READY(READY), .DONE(DONE),
    .CMD_ERR(CMD_ERR), .UNDO_COUNT(UNDO_COUNT), .BOARD_OUT(BOARD_OUT)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {int src; int dst; int sp; int dold;} rec_t;
  typedef struct {int cyc; bit err; bit chk_board; int cnt; logic [N*PWD-1:0] brd;} exp_t;

  int   mb [N];
  rec_t hist [$];
  exp_t q [$];
  exp_t e;

  function automatic logic [N*PWD-1:0] flat_of(input int b [N]);
    logic [N*PWD-1:0] f;
    for (int k = 0; k < N; k++) f[k*PWD +: PWD] = PWD'(b[k]);
    return f;
  endfunction

  task automatic init_model();
    int pat [8] = '{4, 2, 3, 5, 6, 3, 2, 4};
    for (int r = 0; r < (1 << RB); r++)
      for (int c = 0; c < (1 << CB); c++) begin
        int v;
        v = 0;
        if (r == 0)                   v = 8 + pat[c % 8];
        else if (r == 1)              v = 9;
        else if (r == (1 << RB) - 2)  v = 1;
        else if (r == (1 << RB) - 1)  v = pat[c % 8];
        mb[r * (1 << CB) + c] = v;
      end
    hist.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    MOVE_VALID = 1'b0; UNDO_VALID = 1'b0; WR_VALID = 1'b0;
  endtask

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic chk_board(input string nm, input logic [N*PWD-1:0] expv);
    checks++;
    if (BOARD_OUT !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, BOARD_OUT, expv);
    end
  endtask

  function automatic int sq(input int k);
    return int'(BOARD_OUT[k*PWD +: PWD]);
  endfunction

  task automatic wait_ready();
    for (int i = 0; i < 10; i++) begin
      if (READY === 1'b1) return;
      step();
    end
    checks++;
    errors++;
    $display("FAIL ready_timeout: got READY=%0b expected 1", READY);
  endtask

  task automatic push_exp(input int c, input bit err, input bit cb, input int cnt);
    exp_t x;
    x.cyc = c; x.err = err; x.chk_board = cb; x.cnt = cnt; x.brd = flat_of(mb);
    q.push_back(x);
  endtask

  // Issue one request set; the model applies the command rules and queues the responses.
  task automatic issue(input bit mv, input int src, input int dst, input bit un,
                       input bit wr, input int wa, input int wp, input bit junk);
    int   c;
    bit   err, long_op;
    rec_t r;
    wait_ready();
    MOVE_VALID = mv; MOVE_SRC = AW'(src); MOVE_DST = AW'(dst);
    UNDO_VALID = un; WR_VALID = wr; WR_ADDR = AW'(wa); WR_PIECE = PWD'(wp);
    c = cyc;
    err = 1'b0; long_op = 1'b0;
    if (un) begin
      err = mv | wr;
      if (hist.size() == 0) err = 1'b1;
      else begin
        r = hist[$];
        hist.pop_back();
        mb[r.dst] = r.dold;
        mb[r.src] = r.sp;
        long_op = 1'b1;
      end
    end else if (mv) begin
      err = wr;
      if (src == dst || mb[src] % 8 == 0) err = 1'b1;
      else begin
        hist.push_back('{src, dst, mb[src], mb[dst]});
        if (hist.size() > DEPTH) hist.pop_front();
        mb[dst] = mb[src];
        mb[src] = 0;
        long_op = 1'b1;
      end
    end else if (wr) begin
      mb[wa] = wp;
      hist.delete();
    end
    if (err) push_exp(c + 1, 1'b1, !long_op, hist.size());
    if (long_op) push_exp(c + 2, 1'b0, 1'b1, hist.size());
    else if (!err && wr) push_exp(c + 1, 1'b0, 1'b1, 0);
    step();
    clear_in();
    if (long_op) begin
      chk("ready_low_second_cycle", int'(READY), 0);
      if (junk) begin
        MOVE_VALID = 1'($urandom_range(0, 1)); UNDO_VALID = 1'($urandom_range(0, 1));
        WR_VALID = 1'($urandom_range(0, 1));
        MOVE_SRC = AW'($urandom); MOVE_DST = AW'($urandom);
        WR_ADDR = AW'($urandom); WR_PIECE = PWD'($urandom);
      end
      step();
      clear_in();
    end
  endtask

  task automatic pick_move(output int s, output int d);
    s = 0;
    for (int i = 0; i < 1000; i++) begin
      s = $urandom_range(0, N - 1);
      if (mb[s] % 8 != 0) break;
    end
    d = $urandom_range(0, N - 1);
    if (d == s) d = (s + 1) % N;
  endtask

  function automatic int rand_piece();
    return ($urandom_range(0, 1) << 3) | $urandom_range(0, 6);
  endfunction

  // Monitor: every DONE/CMD_ERR pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_resp: got nothing at cyc %0d expected err=%0b", e.cyc, e.err);
    end
    if (RESET === 1'b0 && (DONE === 1'b1 || CMD_ERR === 1'b1)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp: got done=%0b cmd_err=%0b at cyc %0d expected none",
                 DONE, CMD_ERR, cyc);
      end else begin
        e = q.pop_front();
        if (DONE !== !e.err || CMD_ERR !== e.err || cyc != e.cyc || int'(UNDO_COUNT) != e.cnt ||
            (e.chk_board && BOARD_OUT !== e.brd)) begin
          errors++;
          $display("FAIL resp: got cyc=%0d done=%0b err=%0b cnt=%0d board=%h expected cyc=%0d err=%0b cnt=%0d board=%h",
                   cyc, DONE, CMD_ERR, UNDO_COUNT, BOARD_OUT, e.cyc, e.err, e.cnt, e.brd);
        end
      end
    end
  end

  initial begin
    int s, d, wa, wp, keep;
    int snap [N];
    logic [N*PWD-1:0] zero_b;
    zero_b = '0;
    clear_in();
    MOVE_SRC = '0; MOVE_DST = '0; WR_ADDR = '0; WR_PIECE = '0;
    RESET = 1'b1;
    step(); step();
    chk("reset_ready", int'(READY), 0);
    chk("reset_done", int'(DONE), 0);
    chk("reset_cmd_err", int'(CMD_ERR), 0);
    chk("reset_count", int'(UNDO_COUNT), 0);
    chk_board("reset_board", zero_b);

    // Requests during INIT must be ignored without CMD_ERR.
    RESET = 1'b0;
    MOVE_VALID = 1'b1; MOVE_SRC = AW'(52); MOVE_DST = AW'(36); UNDO_VALID = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("init_sq4_written", sq(4), 4'b1110);
    chk("init_sq5_pending", sq(5), 0);
    for (int i = 0; i < 5; i++) step();
    clear_in();
    for (int i = 0; i < 53; i++) step();
    chk("ready_before_64", int'(READY), 0);
    step();
    chk("ready_at_64", int'(READY), 1);
    init_model();
    chk_board("init_board", flat_of(mb));
    chk("init_sq0", sq(0), 4'b1100);
    chk("init_sq52", sq(52), 4'b0001);
    chk("init_sq60", sq(60), 4'b0110);
    chk("init_sq27", sq(27), 0);

    // Move and undo, then capture and undo.
    issue(1, 52, 36, 0, 0, 0, 0, 0);
    wait_ready();
    chk("move_sq36", sq(36), 4'b0001);
    chk("move_sq52", sq(52), 0);
    chk("move_count", int'(UNDO_COUNT), 1);
    issue(0, 0, 0, 1, 0, 0, 0, 0);
    wait_ready();
    chk_board("undo_restores_init", flat_of(mb));
    issue(1, 52, 12, 0, 0, 0, 0, 1);
    issue(0, 0, 0, 1, 0, 0, 0, 0);
    wait_ready();
    chk("capture_undo_sq12", sq(12), 4'b1001);

    // Rejected commands.
    issue(0, 0, 0, 1, 0, 0, 0, 0);
    issue(1, 20, 28, 0, 0, 0, 0, 0);
    issue(1, 52, 52, 0, 0, 0, 0, 0);

    // History overflow with depth 4.
    for (int i = 0; i < 6; i++) begin
      pick_move(s, d);
      issue(1, s, d, 0, 0, 0, 0, 0);
      if (i == 1) snap = mb;
    end
    wait_ready();
    chk("overflow_count", int'(UNDO_COUNT), DEPTH);
    for (int i = 0; i < DEPTH; i++) issue(0, 0, 0, 1, 0, 0, 0, 0);
    wait_ready();
    chk_board("overflow_restores_move2", flat_of(snap));
    issue(0, 0, 0, 1, 0, 0, 0, 0);

    // Simultaneous requests: undo wins, one CMD_ERR, write target untouched.
    pick_move(s, d);
    issue(1, s, d, 0, 0, 0, 0, 0);
    wa = $urandom_range(0, N - 1);
    keep = mb[wa];
    pick_move(s, d);
    issue(1, s, d, 1, 1, wa, rand_piece(), 0);
    wait_ready();
    chk("arb_wr_addr_unchanged", sq(wa), (wa == -1) ? 0 : mb[wa]);
    chk("arb_wr_addr_model", mb[wa], keep);

    // Direct write invalidates history.
    issue(1, 60, 27, 0, 0, 0, 0, 0);
    issue(0, 0, 0, 0, 1, 5, 4'b0101, 0);
    issue(0, 0, 0, 1, 0, 0, 0, 0);

    // Randomised command mix.
    for (int i = 0; i < 300; i++) begin
      int kind;
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1, 2, 3: begin pick_move(s, d); issue(1, s, d, 0, 0, 0, 0, $urandom_range(0, 1)); end
        4, 5:       issue(0, 0, 0, 1, 0, 0, 0, $urandom_range(0, 1));
        6:          issue(1, $urandom_range(0, N - 1), $urandom_range(0, N - 1), 0, 0, 0, 0, 0);
        7:          issue(0, 0, 0, 0, 1, $urandom_range(0, N - 1), rand_piece(), 0);
        default:    begin
          pick_move(s, d);
          issue($urandom_range(0, 1), s, d, $urandom_range(0, 1), 1,
                $urandom_range(0, N - 1), rand_piece(), 1);
        end
      endcase
    end

    // Reset during the second move cycle aborts the command.
    wait_ready();
    step(); step(); step();
    pick_move(s, d);
    MOVE_VALID = 1'b1; MOVE_SRC = AW'(s); MOVE_DST = AW'(d);
    step();
    clear_in();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    chk_board("midop_reset_clear", zero_b);
    chk("midop_reset_count", int'(UNDO_COUNT), 0);
    chk("midop_reset_ready", int'(READY), 0);
    for (int i = 0; i < N; i++) step();
    init_model();
    chk("midop_reinit_ready", int'(READY), 1);
    chk_board("midop_reinit_board", flat_of(mb));

    for (int i = 0; i < 5; i++) step();
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/board_state_mem.md
Name: board_state_mem

Overview:
Parametrised successor to the flat board register array in the chess top level. Holds the board as an R x C array of piece codes and exposes it as a flat bus to the VGA interface and game logic. Adds a sequenced reset-time load of the starting position, atomic two-square move commands, a direct square write (promotion), and a circular undo history. Uses one board write per cycle, so it can later move to block RAM without a redesign.

Parameters:
ROW_BITS, 3, log2 of row count R
COL_BITS, 3, log2 of column count C; square address = {row, col}, width A = ROW_BITS+COL_BITS, N = 2^A squares
PIECE_W, 4, piece code width (min 4); bit PIECE_W-1 = color (0 white, 1 black), bits [2:0] = type (0 none, 1 pawn, 2 knight, 3 bishop, 4 rook, 5 queen, 6 king), other bits 0
UNDO_DEPTH, 16, undo records held (power of 2, >=2)

Ports:
CLK  in  1  single clock (game logic clock)
RESET  in  1  synchronous, active-high
MOVE_VALID  in  1  move request
MOVE_SRC  in  A  source square
MOVE_DST  in  A  destination square
UNDO_VALID  in  1  undo request
WR_VALID  in  1  direct square write request
WR_ADDR  in  A  direct write square
WR_PIECE  in  PIECE_W  direct write value
READY  out  1  idle; commands accepted only when high
DONE  out  1  one-cycle pulse; command fully applied
CMD_ERR  out  1  one-cycle pulse; command rejected
UNDO_COUNT  out  log2(UNDO_DEPTH)+1  valid undo records
BOARD_OUT  out  N*PIECE_W  square k occupies bits [k*PIECE_W +: PIECE_W]

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (CLK, RESET).
- Reset cycle: all squares <= 0; READY=0, DONE=0, CMD_ERR=0, UNDO_COUNT=0, undo pointers=0; state <= INIT with k=0. RESET mid-command aborts it, and the partial board is cleared.
- Outputs are registered.
- INIT: one square per cycle. Square k (k=0..N-1) is written on the k-th cycle after RESET falls.
- INIT layout:
  - row 0: black back rank
  - row 1: black pawns
  - row R-2: white pawns
  - row R-1: white back rank
  - all other rows: 0
  - back rank type at column c = pattern[c mod 8], pattern = R N B Q K B N R
- INIT exit: after square N-1 the state goes to IDLE, and READY=1 from cycle N. Requests during INIT are ignored silently (no CMD_ERR).
- IDLE arbitration: if several requests are high in one cycle, priority is UNDO > MOVE > WR. The winner executes. Each loser pulses CMD_ERR next cycle, with no other effect.
- MOVE (accepted cycle T, state -> MOVE2):
  - T: board[DST] <= board[SRC].
  - T: push record {src, dst, src_piece, dst_old} at wr_ptr; wr_ptr+1 mod UNDO_DEPTH; UNDO_COUNT+1, saturating at UNDO_DEPTH. When full, the oldest record is overwritten.
  - T+1: board[SRC] <= 0; state -> IDLE.
  - T+2: DONE=1, READY=1. READY is 0 in T+1.
- MOVE rejects (CMD_ERR at T+1; no board or history change, READY stays 1): SRC==DST, or board[SRC] type==0.
- UNDO (accepted at T, state -> UNDO2):
  - T: pop the newest record; wr_ptr-1 mod UNDO_DEPTH; UNDO_COUNT-1; board[dst] <= dst_old.
  - T+1: board[src] <= src_piece.
  - T+2: DONE, READY.
  - UNDO with UNDO_COUNT==0: CMD_ERR only.
- WR (at T): board[WR_ADDR] <= WR_PIECE; UNDO_COUNT <= 0 (history invalidated); DONE at T+1; READY stays 1.
- Not accepted: requests while READY=0 (MOVE2/UNDO2) are ignored without CMD_ERR. The requester must hold or reissue.
- Address range: addresses are full-range, so there is no out-of-range case.

Test Plan:
- Init: pulse RESET 1 cycle, wait 64 cycles (8x8) -> READY rises exactly cycle 64. Square 0 = 4'b1100 (black rook), square 4 = 4'b1110, square 52 = 4'b0001, square 60 = 4'b0110, square 27 = 0.
- Move/undo: MOVE 52->36 -> DONE at T+2, square 36 = 4'b0001, square 52 = 0, UNDO_COUNT=1. UNDO -> board restored exactly, UNDO_COUNT=0.
- Capture undo: move white pawn onto black pawn square 12, then UNDO -> square 12 = 4'b1001 again.
- Errors: UNDO at count 0, MOVE 20->28 (empty src), MOVE 52->52 -> each gives CMD_ERR one cycle, board unchanged, no DONE.
- Overflow: UNDO_DEPTH=4, 6 legal moves -> UNDO_COUNT=4. 4 undos restore the position after move 2. A 5th undo -> CMD_ERR.
- Mid-operation: RESET asserted in the MOVE2 cycle -> board cleared, INIT re-runs, no DONE. Also MOVE+UNDO+WR asserted together with count>0 -> undo executes, CMD_ERR pulses once, and WR_ADDR is unchanged.
